// File: rtl/dct_idct_8x8.sv
// 8x8 separable DCT/IDCT: loads 64 raster samples, runs two serial MAC passes, streams 64 results.
// Build macro DCT_IDCT_ROUND_EN selects round-half-away-from-zero in the second-pass scaling.
module dct_idct_8x8 #(
    parameter int DATA_W = 10,
    parameter int OUT_W  = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     busy
);

    localparam int T_W   = DATA_W + 11;
    localparam int ACC_W = DATA_W + 22;
    localparam int P_W   = T_W + 8;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_PASS1 = 2'd1;
    localparam logic [1:0] S_PASS2 = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;
    localparam logic signed [ACC_W-1:0] ONE  = ACC_W'(1);
`ifdef DCT_IDCT_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(32768);
`endif

    // A[k][n]: row 0 is flat, other rows fold (2n+1)k onto the first cosine quadrant
    function automatic logic signed [7:0] coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0] a;
        logic [4:0] m;
        logic       neg;
        logic [7:0] mag;
        a   = {1'b0, n, 1'b1};
        m   = a * {2'b00, k};
        if (m > 5'd16) m = 5'd0 - m;
        neg = (m > 5'd8);
        if (neg) m = 5'd16 - m;
        case (m)
            5'd1:    mag = 8'd125;
            5'd2:    mag = 8'd118;
            5'd3:    mag = 8'd106;
            5'd4:    mag = 8'd90;
            5'd5:    mag = 8'd71;
            5'd6:    mag = 8'd48;
            5'd7:    mag = 8'd24;
            default: mag = 8'd0;
        endcase
        if (k == 3'd0) return 8'sd90;
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] v;
`ifdef DCT_IDCT_ROUND_EN
        v = s[ACC_W-1] ? s - HALF : s + HALF;
`else
        v = s;
`endif
        if (v[ACC_W-1] && (v[15:0] != 16'd0)) return (v >>> 16) + ONE;
        return v >>> 16;
    endfunction

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > OMAX) return OMAX[OUT_W-1:0];
        if (v < OMIN) return OMIN[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction

    logic [1:0]               state_q, state_d;
    logic [8:0]               cnt_q, cnt_d;
    logic                     ovld_q, ovld_d;
    logic signed [OUT_W-1:0]  odata_q, odata_d;
    logic                     mode_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic signed [DATA_W-1:0] xmem [64];
    logic signed [T_W-1:0]    tmem [64];
    logic signed [OUT_W-1:0]  ymem [64];

    logic [2:0]               kk;
    logic [2:0]               other;
    logic signed [7:0]        coef_w;
    logic signed [T_W-1:0]    opnd;
    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovld_d  = ovld_q;
        odata_d = odata_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q[5:0] == 6'd63) begin
                        state_d = S_PASS1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_PASS1: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == 9'd511) state_d = S_PASS2;
            end
            S_PASS2: begin
                cnt_d = cnt_q + 9'd1;
                if (cnt_q == 9'd511) state_d = S_OUT;
            end
            S_OUT: begin
                // one registered-read cycle before the first sample is presented
                if (!ovld_q) begin
                    ovld_d  = 1'b1;
                    odata_d = ymem[0];
                end else if (out_ready) begin
                    if (cnt_q[5:0] == 6'd63) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        ovld_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + 9'd1;
                        odata_d = ymem[cnt_q[5:0] + 6'd1];
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            ovld_q  <= 1'b0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovld_q  <= ovld_d;
            odata_q <= odata_d;
        end
    end

    // PASS1 walks (i,j,k) over X; PASS2 walks (i,j,k) over T; k is the MAC index
    assign kk       = cnt_q[2:0];
    assign other    = (state_q == S_PASS1) ? cnt_q[8:6] : cnt_q[5:3];
    assign coef_w   = mode_q ? coef(other, kk) : coef(kk, other);
    assign opnd     = (state_q == S_PASS1) ? T_W'(xmem[{kk, cnt_q[5:3]}]) : tmem[{cnt_q[8:6], kk}];
    assign prod     = opnd * coef_w;
    assign acc_base = (kk == 3'd0) ? '0 : acc_q;
    assign sum      = acc_base + ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid && !reset) begin
            xmem[cnt_q[5:0]] <= in_data;
            if (cnt_q[5:0] == 6'd0) mode_q <= mode;
        end
        if (state_q == S_PASS1 || state_q == S_PASS2) begin
            acc_q <= sum;
            if (kk == 3'd7) begin
                if (state_q == S_PASS1) tmem[cnt_q[8:3]] <= sum[T_W-1:0];
                else                    ymem[cnt_q[8:3]] <= sat(scale(sum));
            end
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q != S_LOAD);
    assign out_valid = ovld_q;
    assign out_data  = odata_q;

endmodule

// File: tb/tb_dct_idct_8x8.sv
// Bench for dct_idct_8x8: matrix-level reference model, streaming output checker, directed vectors.
module tb_dct_idct_8x8;

    localparam int DW = 10;
    localparam int OW = 10;

    logic                 clk;
    logic                 reset;
    logic                 mode;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 busy;

    dct_idct_8x8 #(.DATA_W(DW), .OUT_W(OW)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int A_TAB [8][8] = '{
        '{ 90,  90,  90,  90,  90,  90,  90,  90},
        '{125, 106,  71,  24, -24, -71,-106,-125},
        '{118,  48, -48,-118,-118, -48,  48, 118},
        '{106, -24,-125, -71,  71, 125,  24,-106},
        '{ 90, -90, -90,  90,  90, -90, -90,  90},
        '{ 71,-125,  24, 106,-106, -24, 125, -71},
        '{ 48,-118, 118, -48, -48, 118,-118,  48},
        '{ 24, -71, 106,-125, 125,-106,  71, -24}
    };

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stim [64];
    int mdl [64];
    int got_arr [64];
    int got_idx = 0;
    int exp_q [$];
    int last_in_cyc = 0;
    int rise_cyc = -1;
    bit prev_ov = 1'b0;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    // Y = A^T X A (IDCT) or A X A^T (DCT), each sum /65536 then clamped
    task automatic compute_expect(input bit md);
        longint t [8][8];
        longint s;
        longint q;
        int     lim;
        lim = (1 << (OW - 1));
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += longint'(md ? A_TAB[i][k] : A_TAB[k][i]) * longint'(stim[k*8+j]);
                t[i][j] = s;
            end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += t[i][k] * longint'(md ? A_TAB[j][k] : A_TAB[k][j]);
`ifdef DCT_IDCT_ROUND_EN
                q = (s >= 0) ? (s + 32768) / 65536 : (s - 32768) / 65536;
`else
                q = s / 65536;
`endif
                if (q > lim - 1) q = lim - 1;
                if (q < -lim) q = -lim;
                mdl[i*8+j] = int'(q);
                exp_q.push_back(int'(q));
            end
    endtask

    task automatic fill(input int sel);
        for (int s = 0; s < 64; s++) begin
            case (sel)
                1: stim[s] = ((s * 37 + 11) % 97) - 48;
                2: stim[s] = ((s * 53 + 7) % 201) - 100;
                3: stim[s] = ((s * 29 + 3) % 1000) - 500;
                default: stim[s] = 0;
            endcase
        end
    endtask

    task automatic fill_const(input int v);
        for (int s = 0; s < 64; s++) stim[s] = v;
    endtask

    // junk=1 keeps in_valid high with garbage while the block is busy
    task automatic send_block(input bit md, input bit junk);
        int s;
        int guard;
        bit rdy;
        s = 0;
        guard = 0;
        while (s < 64) begin
            rdy = in_ready;
            if (rdy) begin
                in_valid = 1'b1;
                in_data  = DW'(stim[s]);
                mode     = (s == 0) ? md : ~md;
            end else begin
                in_valid = junk;
                in_data  = DW'(-300);
                mode     = ~md;
            end
            @(posedge clk); #1;
            if (rdy) begin
                s++;
                if (s == 64) last_in_cyc = cyc;
            end
            guard++;
            if (guard > 5000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got %0d samples expected 64", s);
                break;
            end
        end
        in_valid = 1'b0;
        mode     = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_block(input bit md);
        compute_expect(md);
        got_idx  = 0;
        rise_cyc = -1;
        send_block(md, 1'b0);
        drain();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output checker: every valid cycle must show the head of the expected stream
    initial forever begin
        int gv;
        @(negedge clk);
        if (out_valid && !prev_ov) rise_cyc = cyc;
        prev_ov = out_valid;
        if (out_valid) begin
            checks++;
            gv = out_data;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got %0d expected no output", gv);
            end else begin
                if (gv != exp_q[0]) begin
                    errors++;
                    $display("FAIL out_data[%0d] got %0d expected %0d", got_idx, gv, exp_q[0]);
                end
                if (out_ready) begin
                    if (got_idx < 64) got_arr[got_idx] = gv;
                    got_idx++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int e105;
        int guard;
        reset     = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        reset = 1'b0;

        // IDCT impulse 100 -> flat 12, plus exact latency
        fill(0);
        stim[0] = 100;
        run_block(1'b0);
        chk("model_impulse100", mdl[0], 12);
        chk("impulse100_y0", got_arr[0], 12);
        chk("impulse100_y37", got_arr[37], 12);
        chk("impulse100_y63", got_arr[63], 12);
        chk("latency_a", rise_cyc - last_in_cyc, 1025);

`ifdef DCT_IDCT_ROUND_EN
        e105 = 13;
`else
        e105 = 12;
`endif
        fill(0);
        stim[0] = 105;
        run_block(1'b0);
        chk("impulse105_y0", got_arr[0], e105);
        chk("impulse105_y63", got_arr[63], e105);
        fill(0);
        stim[0] = -105;
        run_block(1'b0);
        chk("impulse_m105_y0", got_arr[0], -e105);
        chk("impulse_m105_y50", got_arr[50], -e105);

        // DCT flat 10 with a 20-cycle sink stall mid-stream
        fill_const(10);
        compute_expect(1'b1);
        chk("model_dc10", mdl[0], 79);
        got_idx  = 0;
        rise_cyc = -1;
        send_block(1'b1, 1'b0);
        guard = 0;
        while (got_idx < 30 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_stall_point", int'(got_idx >= 30), 1);
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("stall_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        drain();
        chk("latency_c", rise_cyc - last_in_cyc, 1025);
        chk("dc10_y0", got_arr[0], 79);
        chk("dc10_y1", got_arr[1], 0);
        chk("dc10_y30", got_arr[30], 0);
        chk("dc10_y63", got_arr[63], 0);
        chk("dc10_count", got_idx, 64);

        fill_const(511);
        run_block(1'b1);
        chk("sat_pos_y0", got_arr[0], 511);
        chk("sat_pos_y9", got_arr[9], 0);
        fill_const(-512);
        run_block(1'b1);
        chk("sat_neg_y0", got_arr[0], -512);

        // Reset in PASS2, with in_valid high on the reset edge
        fill(1);
        compute_expect(1'b1);
        send_block(1'b1, 1'b0);
        repeat (700) @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(busy), 1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'(77);
        @(posedge clk); #1;
        chk("midreset_in_ready", int'(in_ready), 1);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_out_data", int'(out_data), 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        fill(2);
        run_block(1'b0);
        chk("post_reset_count", got_idx, 64);

        // Back-to-back IDCT then DCT, in_valid held with junk while busy
        fill(3);
        compute_expect(1'b0);
        got_idx = 0;
        send_block(1'b0, 1'b1);
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_in_ready", int'(in_ready), 0);
        fill(1);
        compute_expect(1'b1);
        send_block(1'b1, 1'b1);
        drain();
        chk("b2b_count", got_idx, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
